// File: rtl/frame_draw_sequencer.sv
// Time-multiplexes one VGA write port between N_CLIENTS sprite engines.
// Per frame: erase all, tick, redraw all; registered x/y/colour/plot out.
module frame_draw_sequencer #(
  parameter int N_CLIENTS    = 3,
  parameter int FRAME_TICKS  = 833334,
  parameter int ERASE_CYCLES = 8,
  parameter int TIMEOUT      = 256
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [9*N_CLIENTS-1:0] client_x,
  input  logic [8*N_CLIENTS-1:0] client_y,
  input  logic [3*N_CLIENTS-1:0] client_colour,
  input  logic [N_CLIENTS-1:0]   client_finish,
  output logic [N_CLIENTS-1:0]   draw_req,
  output logic [N_CLIENTS-1:0]   erase_req,
  output logic                   frame_tick,
  output logic [8:0]             vga_x,
  output logic [7:0]             vga_y,
  output logic [2:0]             vga_colour,
  output logic                   vga_plot,
  output logic                   busy,
  output logic                   frame_overrun,
  output logic                   timeout_err
);

  localparam int IW = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
  localparam int FW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam int CMAX =
    (ERASE_CYCLES > TIMEOUT) ? ERASE_CYCLES : TIMEOUT;
  localparam int CW = $clog2(CMAX) + 1;

  localparam logic [IW-1:0] LAST   = IW'(N_CLIENTS - 1);
  localparam logic [FW-1:0] F_LAST = FW'(FRAME_TICKS - 1);
  localparam logic [CW-1:0] E_LAST = CW'(ERASE_CYCLES - 1);
  localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ERASE,
    S_TICK,
    S_DRAW
  } state_t;

  state_t        r_state, w_state_n;
  logic [IW-1:0] r_idx, w_idx_n;
  logic [CW-1:0] r_cnt, w_cnt_n;
  logic [FW-1:0] r_fcnt;
  logic          r_pend, w_pend_n;
  logic          w_ovr_n, w_tmo_n;
  logic          w_fstart;
  logic          w_last_draw;
  logic          w_fin;
  logic          w_plotting;
  logic [8:0]    w_sel_x;
  logic [7:0]    w_sel_y;
  logic [2:0]    w_sel_c;

  // Free-running frame counter; its wrap cycle is the frame boundary.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fcnt <= '0;
    end else if (r_fcnt == F_LAST) begin
      r_fcnt <= '0;
    end else begin
      r_fcnt <= r_fcnt + 1'b1;
    end
  end

  assign w_fstart = (r_fcnt == F_LAST);

  always_comb begin
    w_sel_x = '0;
    w_sel_y = '0;
    w_sel_c = '0;
    w_fin   = 1'b0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (r_idx == IW'(i)) begin
        w_sel_x = client_x[9*i +: 9];
        w_sel_y = client_y[8*i +: 8];
        w_sel_c = client_colour[3*i +: 3];
        w_fin   = client_finish[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_idx         <= '0;
      r_cnt         <= '0;
      r_pend        <= 1'b0;
      frame_overrun <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      r_state       <= w_state_n;
      r_idx         <= w_idx_n;
      r_cnt         <= w_cnt_n;
      r_pend        <= w_pend_n;
      frame_overrun <= w_ovr_n;
      timeout_err   <= w_tmo_n;
    end
  end

  always_comb begin
    w_state_n   = r_state;
    w_idx_n     = r_idx;
    w_cnt_n     = r_cnt;
    w_pend_n    = r_pend;
    w_ovr_n     = frame_overrun;
    w_tmo_n     = timeout_err;
    w_last_draw = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_fstart || r_pend) begin
          w_state_n = S_ERASE;
          w_idx_n   = '0;
          w_cnt_n   = '0;
          w_pend_n  = 1'b0;
        end
      end
      S_ERASE: begin
        if (r_cnt == E_LAST) begin
          w_cnt_n = '0;
          if (r_idx == LAST) begin
            w_state_n = S_TICK;
            w_idx_n   = '0;
          end else begin
            w_idx_n = r_idx + 1'b1;
          end
        end else begin
          w_cnt_n = r_cnt + 1'b1;
        end
      end
      S_TICK: begin
        w_state_n = S_DRAW;
        w_idx_n   = '0;
        w_cnt_n   = '0;
      end
      S_DRAW: begin
        if (w_fin || (r_cnt == T_LAST)) begin
          // A finish on the timeout cycle still counts as success.
          if (!w_fin) w_tmo_n = 1'b1;
          w_cnt_n = '0;
          if (r_idx == LAST) begin
            w_state_n   = S_IDLE;
            w_idx_n     = '0;
            w_last_draw = 1'b1;
          end else begin
            w_idx_n = r_idx + 1'b1;
          end
        end else begin
          w_cnt_n = r_cnt + 1'b1;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
    // A boundary landing on the return-to-idle cycle is only deferred.
    if (w_fstart && (r_state != S_IDLE)) begin
      w_pend_n = 1'b1;
      if (!w_last_draw) w_ovr_n = 1'b1;
    end
  end

  always_comb begin
    erase_req = '0;
    draw_req  = '0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      erase_req[i] = (r_state == S_ERASE) && (r_idx == IW'(i));
      draw_req[i]  = (r_state == S_DRAW) && (r_idx == IW'(i));
    end
  end

  assign frame_tick = (r_state == S_TICK);
  assign busy       = (r_state != S_IDLE);
  assign w_plotting = (r_state == S_ERASE) || (r_state == S_DRAW);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
    end else begin
      vga_plot <= w_plotting;
      if (w_plotting) begin
        vga_x      <= w_sel_x;
        vga_y      <= w_sel_y;
        vga_colour <= w_sel_c;
      end
    end
  end

endmodule

// File: tb/tb_frame_draw_sequencer.sv
// Bench for frame_draw_sequencer: directed table on a 64-tick frame,
// then randomized run on a 20-tick frame against a schedule model.
module tb_frame_draw_sequencer;

  localparam int N    = 2;
  localparam int EC   = 4;
  localparam int TO   = 16;
  localparam int FT_A = 64;
  localparam int FT_B = 20;
  localparam int NC   = 600;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  // ---------------- DUT A ----------------
  logic         rst_a = 1'b0;
  logic [17:0]  cx_a;
  logic [15:0]  cy_a;
  logic [5:0]   cc_a;
  logic [1:0]   fin_a = '0;
  logic [1:0]   dr_a, er_a;
  logic         tk_a, plot_a, busy_a, ovr_a, tmo_a;
  logic [8:0]   vx_a;
  logic [7:0]   vy_a;
  logic [2:0]   vc_a;

  frame_draw_sequencer #(
    .N_CLIENTS(N), .FRAME_TICKS(FT_A),
    .ERASE_CYCLES(EC), .TIMEOUT(TO)
  ) dut_a (
    .clk(clk), .reset(rst_a),
    .client_x(cx_a), .client_y(cy_a),
    .client_colour(cc_a), .client_finish(fin_a),
    .draw_req(dr_a), .erase_req(er_a), .frame_tick(tk_a),
    .vga_x(vx_a), .vga_y(vy_a), .vga_colour(vc_a),
    .vga_plot(plot_a), .busy(busy_a),
    .frame_overrun(ovr_a), .timeout_err(tmo_a)
  );

  // ---------------- DUT B ----------------
  logic         rst_b = 1'b0;
  logic [17:0]  cx_b = '0;
  logic [15:0]  cy_b = '0;
  logic [5:0]   cc_b = '0;
  logic [1:0]   fin_b_in = '0;
  logic [1:0]   dr_b, er_b;
  logic         tk_b, plot_b, busy_b, ovr_b, tmo_b;
  logic [8:0]   vx_b;
  logic [7:0]   vy_b;
  logic [2:0]   vc_b;

  frame_draw_sequencer #(
    .N_CLIENTS(N), .FRAME_TICKS(FT_B),
    .ERASE_CYCLES(EC), .TIMEOUT(TO)
  ) dut_b (
    .clk(clk), .reset(rst_b),
    .client_x(cx_b), .client_y(cy_b),
    .client_colour(cc_b), .client_finish(fin_b_in),
    .draw_req(dr_b), .erase_req(er_b), .frame_tick(tk_b),
    .vga_x(vx_b), .vga_y(vy_b), .vga_colour(vc_b),
    .vga_plot(plot_b), .busy(busy_b),
    .frame_overrun(ovr_b), .timeout_err(tmo_b)
  );

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0h expected %0h",
               nm, cyc, act, exp);
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    int         len;
    logic [1:0] fin;
    logic [1:0] er;
    logic [1:0] dr;
    logic       tk;
    logic       busy;
    logic       plot;
    logic       tmo;
    logic [8:0] x;
  } vec_t;

  vec_t tbl[$];

  // ---------------- random model state ----------------
  logic [1:0] fin_b [NC+1];
  logic [8:0] xb    [NC+1][N];
  logic [7:0] yb    [NC+1][N];
  logic [2:0] cb    [NC+1][N];
  logic [1:0] e_er  [NC+1];
  logic [1:0] e_dr  [NC+1];
  logic       e_tk  [NC+1];
  logic       e_bsy [NC+1];
  logic       e_plt [NC+1];
  logic [8:0] e_x   [NC+1];
  logic [7:0] e_y   [NC+1];
  logic [2:0] e_c   [NC+1];
  logic       e_ovr [NC+1];
  logic       e_tmo [NC+1];
  logic       m_ovr, m_tmo, m_pend;

  function automatic bit fs(int c);
    return (c % FT_B) == FT_B - 1;
  endfunction

  // st: 0 idle, 1 erase, 2 tick, 3 draw
  task automatic mark(int c, int st, int i);
    logic p;
    if (c < NC) begin
      e_er[c]  = (st == 1) ? 2'(1 << i) : 2'b00;
      e_dr[c]  = (st == 3) ? 2'(1 << i) : 2'b00;
      e_tk[c]  = (st == 2);
      e_bsy[c] = (st != 0);
      e_ovr[c] = m_ovr;
      e_tmo[c] = m_tmo;
      p = (st == 1) || (st == 3);
      e_plt[c+1] = p;
      e_x[c+1] = p ? xb[c][i] : e_x[c];
      e_y[c+1] = p ? yb[c][i] : e_y[c];
      e_c[c+1] = p ? cb[c][i] : e_c[c];
    end
  endtask

  // Builds the whole expected schedule as a sequence of frames.
  task automatic gen();
    int  c;
    int  d;
    bit  go, f, t;
    c = 0;
    m_ovr = 0; m_tmo = 0; m_pend = 0;
    e_x[0] = '0; e_y[0] = '0; e_c[0] = '0; e_plt[0] = 1'b0;
    while (c < NC) begin
      go = 0;
      while (!go && c < NC) begin
        go = fs(c) || m_pend;
        mark(c, 0, 0);
        c++;
      end
      m_pend = 0;
      for (int i = 0; i < N; i++) begin
        for (int k = 0; k < EC; k++) begin
          mark(c, 1, i);
          if (fs(c)) begin m_pend = 1; m_ovr = 1; end
          c++;
        end
      end
      mark(c, 2, 0);
      if (fs(c)) begin m_pend = 1; m_ovr = 1; end
      c++;
      for (int i = 0; i < N; i++) begin
        d = int'($urandom_range(0, TO + 3));
        for (int k = 0; k < 1000; k++) begin
          f = (k == d);
          t = (k == TO - 1);
          if (c < NC) fin_b[c][i] = f;
          mark(c, 3, i);
          if (fs(c)) begin
            m_pend = 1;
            if (!(i == N - 1 && (f || t))) m_ovr = 1;
          end
          if (t && !f) m_tmo = 1;
          c++;
          if (f || t) break;
        end
      end
    end
  endtask

  initial begin
    cx_a = {9'd200, 9'd37};
    cy_a = {8'd22, 8'd11};
    cc_a = {3'd5, 3'd3};

    tbl.push_back('{64, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 9'd0});
    tbl.push_back('{1,  2'b00, 2'b01, 2'b00, 0, 1, 0, 0, 9'd0});
    tbl.push_back('{3,  2'b10, 2'b01, 2'b00, 0, 1, 1, 0, 9'd37});
    tbl.push_back('{1,  2'b00, 2'b10, 2'b00, 0, 1, 1, 0, 9'd37});
    tbl.push_back('{3,  2'b00, 2'b10, 2'b00, 0, 1, 1, 0, 9'd200});
    tbl.push_back('{1,  2'b00, 2'b00, 2'b00, 1, 1, 1, 0, 9'd200});
    tbl.push_back('{1,  2'b00, 2'b00, 2'b01, 0, 1, 0, 0, 9'd200});
    tbl.push_back('{4,  2'b10, 2'b00, 2'b01, 0, 1, 1, 0, 9'd37});
    tbl.push_back('{1,  2'b01, 2'b00, 2'b01, 0, 1, 1, 0, 9'd37});
    tbl.push_back('{1,  2'b00, 2'b00, 2'b10, 0, 1, 1, 0, 9'd37});
    tbl.push_back('{15, 2'b01, 2'b00, 2'b10, 0, 1, 1, 0, 9'd200});
    tbl.push_back('{1,  2'b00, 2'b00, 2'b00, 0, 0, 1, 1, 9'd200});
    tbl.push_back('{10, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1, 9'd200});

    repeat (3) @(negedge clk);
    rst_a = 1'b1;
    cyc = 0;
    foreach (tbl[j]) begin
      for (int r = 0; r < tbl[j].len; r++) begin
        fin_a = tbl[j].fin;
        #1;
        chk("erase_req", 32'(er_a),   32'(tbl[j].er));
        chk("draw_req",  32'(dr_a),   32'(tbl[j].dr));
        chk("frame_tick",32'(tk_a),   32'(tbl[j].tk));
        chk("busy",      32'(busy_a), 32'(tbl[j].busy));
        chk("vga_plot",  32'(plot_a), 32'(tbl[j].plot));
        chk("timeout",   32'(tmo_a),  32'(tbl[j].tmo));
        chk("vga_x",     32'(vx_a),   32'(tbl[j].x));
        chk("overrun",   32'(ovr_a),  32'(1'b0));
        @(negedge clk);
        cyc++;
      end
    end

    // Second frame: client 0 times out, client 1 drawing from cycle 153.
    fin_a = 2'b00;
    while (cyc < 155) begin
      @(negedge clk);
      cyc++;
    end
    #1;
    chk("mid draw_req", 32'(dr_a),   32'(2'b10));
    chk("mid busy",     32'(busy_a), 32'(1'b1));
    #3 rst_a = 1'b0;
    #1;
    chk("rst draw_req", 32'(dr_a),   32'(2'b00));
    chk("rst busy",     32'(busy_a), 32'(1'b0));
    chk("rst plot",     32'(plot_a), 32'(1'b0));
    chk("rst timeout",  32'(tmo_a),  32'(1'b0));
    chk("rst vga_x",    32'(vx_a),   32'(9'd0));
    @(negedge clk);
    rst_a = 1'b1;
    cyc = 0;
    for (int c = 0; c <= 64; c++) begin
      #1;
      chk("restart erase", 32'(er_a),
          (c == 64) ? 32'd1 : 32'd0);
      chk("restart busy", 32'(busy_a),
          (c == 64) ? 32'd1 : 32'd0);
      @(negedge clk);
      cyc++;
    end

    // Randomized run on the short-frame instance.
    for (int c = 0; c <= NC; c++) begin
      fin_b[c] = 2'($urandom_range(0, 3));
      for (int i = 0; i < N; i++) begin
        xb[c][i] = 9'($urandom);
        yb[c][i] = 8'($urandom);
        cb[c][i] = 3'($urandom);
      end
    end
    gen();

    rst_b = 1'b1;
    cyc = 0;
    for (int c = 0; c < NC; c++) begin
      fin_b_in = fin_b[c];
      cx_b = {xb[c][1], xb[c][0]};
      cy_b = {yb[c][1], yb[c][0]};
      cc_b = {cb[c][1], cb[c][0]};
      #1;
      chk("r erase_req", 32'(er_b),   32'(e_er[c]));
      chk("r draw_req",  32'(dr_b),   32'(e_dr[c]));
      chk("r frame_tick",32'(tk_b),   32'(e_tk[c]));
      chk("r busy",      32'(busy_b), 32'(e_bsy[c]));
      chk("r vga_plot",  32'(plot_b), 32'(e_plt[c]));
      chk("r vga_x",     32'(vx_b),   32'(e_x[c]));
      chk("r vga_y",     32'(vy_b),   32'(e_y[c]));
      chk("r vga_col",   32'(vc_b),   32'(e_c[c]));
      chk("r overrun",   32'(ovr_b),  32'(e_ovr[c]));
      chk("r timeout",   32'(tmo_b),  32'(e_tmo[c]));
      @(negedge clk);
      cyc++;
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
